gdiv_seq: RTL and testbench

GDIV_SEQ -- requirements
Module: gdiv_seq

---
 rtl/gdiv_pkg.sv | 53 +++++
 rtl/gdiv_seq_if.sv | 27 ++
 rtl/gdiv_iter_cnt.sv | 42 ++++
 rtl/gdiv_seq.sv | 95 +++++++++
 tb/tb_gdiv_seq.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/gdiv_pkg.sv
// Shared definitions for the Goldschmidt divider sequencer: state encoding,
// datapath select codes, control-word layout and its per-state decode.
package gdiv_pkg;

  localparam int ITERS_MAX = 15;
  localparam int ITER_W    = 4;

  typedef enum logic [2:0] {
    IDLE,
    IA_N,
    IA_D,
    IT_N,
    IT_D,
    REM,
    DONE
  } gdiv_state_e;

  localparam logic [1:0] SEL3_APPROX = 2'b00;
  localparam logic [1:0] SEL3_ITER   = 2'b01;
  localparam logic [1:0] SEL3_REM    = 2'b10;

  localparam logic [1:0] SEL4_IA_N = 2'b00;
  localparam logic [1:0] SEL4_IA_D = 2'b01;
  localparam logic [1:0] SEL4_IT_N = 2'b10;
  localparam logic [1:0] SEL4_IT_D = 2'b11;

  typedef struct packed {
    logic [1:0] sel3;
    logic [1:0] sel4;
    logic       en_a;
    logic       en_b;
    logic       en_rem;
    logic       busy;
    logic       done;
  } gdiv_ctrl_t;

  // The remainder step reuses the numerator-side operand of the iteration.
  function automatic gdiv_ctrl_t ctrl_decode(gdiv_state_e s);
    gdiv_ctrl_t c;
    c = '0;
    case (s)
      IA_N: begin c.sel4 = SEL4_IA_N; c.sel3 = SEL3_APPROX; c.en_a = 1'b1;   c.busy = 1'b1; end
      IA_D: begin c.sel4 = SEL4_IA_D; c.sel3 = SEL3_APPROX; c.en_b = 1'b1;   c.busy = 1'b1; end
      IT_N: begin c.sel4 = SEL4_IT_N; c.sel3 = SEL3_ITER;   c.en_a = 1'b1;   c.busy = 1'b1; end
      IT_D: begin c.sel4 = SEL4_IT_D; c.sel3 = SEL3_ITER;   c.en_b = 1'b1;   c.busy = 1'b1; end
      REM:  begin c.sel4 = SEL4_IT_N; c.sel3 = SEL3_REM;    c.en_rem = 1'b1; c.busy = 1'b1; end
      DONE: begin c.busy = 1'b1; c.done = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/gdiv_seq_if.sv
// Control bundle between the divider sequencer and its datapath / requester.
interface gdiv_seq_if;
  import gdiv_pkg::*;

  logic              start;
  logic              abort;
  logic              rm_in;
  logic              rm;
  logic [1:0]        sel_mux3;
  logic [1:0]        sel_mux4;
  logic              en_a;
  logic              en_b;
  logic              en_rem;
  logic              busy;
  logic              done;
  logic [ITER_W-1:0] iter;

  modport master (
    output start, abort, rm_in,
    input  rm, sel_mux3, sel_mux4, en_a, en_b, en_rem, busy, done, iter
  );

  modport slave (
    input  start, abort, rm_in,
    output rm, sel_mux3, sel_mux4, en_a, en_b, en_rem, busy, done, iter
  );
endinterface

// File: rtl/gdiv_iter_cnt.sv
// Goldschmidt iteration counter: clear, load-to-one, increment, and a flag
// raised while the final iteration pair is in progress.
module gdiv_iter_cnt
  import gdiv_pkg::*;
#(
  parameter int ITERS = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic              inc_i,
  output logic [ITER_W-1:0] cnt_o,
  output logic              last_o
);

  logic [ITER_W-1:0] cnt_q;
  logic [ITER_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = ITER_W'(1);
    end else if (inc_i) begin
      cnt_d = cnt_q + ITER_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == ITER_W'(ITERS));

endmodule

// File: rtl/gdiv_seq.sv
// Goldschmidt divider control sequencer (Moore FSM, registered outputs).
// Optional remainder step is built when GDIV_SEQ_REM_EN is defined.
module gdiv_seq
  import gdiv_pkg::*;
#(
  parameter int ITERS = 6
) (
  input  logic       clk,
  input  logic       reset,
  gdiv_seq_if.slave  bus
);

  if (ITERS < 1 || ITERS > ITERS_MAX) begin : g_iters_range
    $error("gdiv_seq: ITERS=%0d outside 1..%0d", ITERS, ITERS_MAX);
  end

`ifdef GDIV_SEQ_REM_EN
  localparam gdiv_state_e AFTER_LAST = REM;
`else
  localparam gdiv_state_e AFTER_LAST = DONE;
`endif

  gdiv_state_e       state_q;
  gdiv_state_e       state_d;
  gdiv_ctrl_t        ctrl_q;
  logic              rm_q;
  logic              rm_d;
  logic              accept;
  logic              last;
  logic [ITER_W-1:0] iter;

  assign accept = (state_q == IDLE) && bus.start && !bus.abort;

  always_comb begin
    state_d = state_q;
    if (state_q != IDLE && bus.abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:       if (accept) state_d = IA_N;
        IA_N:       state_d = IA_D;
        IA_D, IT_D: state_d = last ? AFTER_LAST : IT_N;
        IT_N:       state_d = IT_D;
        REM:        state_d = DONE;
        DONE:       state_d = IDLE;
        default:    state_d = IDLE;
      endcase
    end
  end

  assign rm_d = accept ? bus.rm_in : rm_q;

  // Outputs are decoded from the next state so they line up with state_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ctrl_q  <= '0;
      rm_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_decode(state_d);
      rm_q    <= rm_d;
    end
  end

  gdiv_iter_cnt #(
    .ITERS (ITERS)
  ) u_iter_cnt (
    .clk     (clk),
    .reset   (reset),
    .clear_i (state_d == IDLE),
    .load_i  (accept),
    .inc_i   (state_d == IT_N),
    .cnt_o   (iter),
    .last_o  (last)
  );

  assign bus.rm       = rm_q;
  assign bus.sel_mux3 = ctrl_q.sel3;
  assign bus.sel_mux4 = ctrl_q.sel4;
  assign bus.en_a     = ctrl_q.en_a;
  assign bus.en_b     = ctrl_q.en_b;
  assign bus.busy     = ctrl_q.busy;
  assign bus.done     = ctrl_q.done;
  assign bus.iter     = iter;

`ifdef GDIV_SEQ_REM_EN
  assign bus.en_rem = ctrl_q.en_rem;
`else
  logic unused_en_rem;
  assign unused_en_rem = ctrl_q.en_rem;
  assign bus.en_rem    = 1'b0;
`endif

endmodule

// File: tb/tb_gdiv_seq.sv
// Directed bench for gdiv_seq: ITERS=6 and ITERS=1 instances on one clock;
// expected sequences adapt to whether GDIV_SEQ_REM_EN is defined.
module tb_gdiv_seq;

`ifdef GDIV_SEQ_REM_EN
  localparam int REM_CYC = 1;
`else
  localparam int REM_CYC = 0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;

  gdiv_seq_if bus6 ();
  gdiv_seq_if bus1 ();

  gdiv_seq #(.ITERS(6)) dut6 (.clk(clk), .reset(reset), .bus(bus6.slave));
  gdiv_seq #(.ITERS(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic s, input logic a, input logic r);
    if (sel == 6) begin
      bus6.start = s; bus6.abort = a; bus6.rm_in = r;
    end else begin
      bus1.start = s; bus1.abort = a; bus1.rm_in = r;
    end
  endtask

  // {iter[3:0], sel4[1:0], sel3[1:0], en_a, en_b, en_rem, busy, done}
  function automatic logic [12:0] obs(input int sel);
    if (sel == 6)
      return {bus6.iter, bus6.sel_mux4, bus6.sel_mux3, bus6.en_a, bus6.en_b,
              bus6.en_rem, bus6.busy, bus6.done};
    return {bus1.iter, bus1.sel_mux4, bus1.sel_mux3, bus1.en_a, bus1.en_b,
            bus1.en_rem, bus1.busy, bus1.done};
  endfunction

  function automatic logic get_rm(input int sel);
    return (sel == 6) ? bus6.rm : bus1.rm;
  endfunction

  // Expected outputs k cycles after the accepted-start edge.
  function automatic logic [12:0] exp_vec(input int iters, input int k);
    logic [3:0] it;
    logic [1:0] s4, s3;
    logic a, b, r, bz, d;
    it = 4'd0; s4 = 2'b00; s3 = 2'b00; a = 1'b0; b = 1'b0; r = 1'b0; bz = 1'b0; d = 1'b0;
    if (k < 2 * iters) begin
      it = 4'(k / 2 + 1);
      bz = 1'b1;
      a  = (k % 2 == 0);
      b  = (k % 2 == 1);
      if (k == 0)      begin s4 = 2'b00; s3 = 2'b00; end
      else if (k == 1) begin s4 = 2'b01; s3 = 2'b00; end
      else             begin s4 = (k % 2 == 0) ? 2'b10 : 2'b11; s3 = 2'b01; end
    end else if (k < 2 * iters + REM_CYC) begin
      it = 4'(iters); bz = 1'b1; r = 1'b1; s4 = 2'b10; s3 = 2'b10;
    end else if (k == 2 * iters + REM_CYC) begin
      it = 4'(iters); bz = 1'b1; d = 1'b1;
    end
    return {it, s4, s3, a, b, r, bz, d};
  endfunction

  task automatic run_seq(input int sel, input int iters, input logic rmv, input string name);
    int lat;
    int n_a, n_b, n_r, done_at;
    logic rm_ok;
    logic [12:0] o;
    lat = 2 * iters + REM_CYC;
    n_a = 0; n_b = 0; n_r = 0; done_at = -1; rm_ok = 1'b1;
    drive(sel, 1'b1, 1'b0, rmv);
    for (int k = 0; k <= lat + 1; k++) begin
      @(posedge clk); #1;
      if (k == 0) drive(sel, 1'b0, 1'b0, ~rmv);
      o = obs(sel);
      check_value($sformatf("%s_cyc%0d", name, k), 32'(o), 32'(exp_vec(iters, k)));
      if (o[4]) n_a++;
      if (o[3]) n_b++;
      if (o[2]) n_r++;
      if (o[0] && done_at < 0) done_at = k;
      if (k <= lat && get_rm(sel) !== rmv) rm_ok = 1'b0;
    end
    check_value({name, "_latency"}, 32'(done_at), 32'(lat));
    check_value({name, "_n_en_a"}, 32'(n_a), 32'(iters));
    check_value({name, "_n_en_b"}, 32'(n_b), 32'(iters));
    check_value({name, "_n_en_rem"}, 32'(n_r), 32'(REM_CYC));
    check_value({name, "_rm_stable"}, 32'(rm_ok), 32'(1));
    $display("seq %s: iters=%0d rm=%0d done_at=%0d en_a=%0d en_b=%0d en_rem=%0d",
             name, iters, rmv, done_at, n_a, n_b, n_r);
  endtask

  task automatic watch_no_done(input int cycles, input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (bus6.done) seen = 1'b1;
    end
    check_value(name, 32'(seen), 32'(0));
  endtask

  initial begin
    int c1, c2, done1;
    logic found;
    drive(6, 1'b0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b0);

    // Reset state
    #2 reset = 1'b1;
    #1;
    check_value("rst_obs6", 32'(obs(6)), 32'(0));
    check_value("rst_obs1", 32'(obs(1)), 32'(0));
    check_value("rst_rm6", 32'(get_rm(6)), 32'(0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    $display("reset released");

    // Full sequences
    run_seq(6, 6, 1'b1, "it6");
    run_seq(1, 1, 1'b1, "it1");

    // Abort in IT_N at iter 3
    drive(6, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(6, 1'b0, 1'b0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus6.iter == 4'd3 && bus6.sel_mux4 == 2'b10 && bus6.en_a) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check_value("abort_reach_it_n3", 32'(found), 32'(1));
    drive(6, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(6, 1'b0, 1'b0, 1'b0);
    check_value("abort_idle_obs", 32'(obs(6)), 32'(0));
    watch_no_done(20, "abort_no_done");
    $display("abort at iter 3 done");

    // Abort beats start in IDLE
    drive(6, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(6, 1'b0, 1'b0, 1'b0);
    check_value("abort_beats_start", 32'(bus6.busy), 32'(0));
    $display("abort+start in idle done");

    // Start held high: back-to-back sequences
    drive(6, 1'b1, 1'b0, 1'b0);
    c1 = -1; c2 = -1; done1 = 0;
    for (int c = 0; c < 60 && c2 < 0; c++) begin
      @(posedge clk); #1;
      if (bus6.busy && bus6.iter == 4'd1 && bus6.sel_mux4 == 2'b00 && bus6.en_a) begin
        if (c1 < 0) begin
          c1 = c;
          drive(6, 1'b1, 1'b0, 1'b1);
        end else begin
          c2 = c;
          check_value("b2b_rm_capture", 32'(bus6.rm), 32'(1));
        end
      end
      if (bus6.done && done1 == 0) begin
        done1 = 1;
        check_value("b2b_rm_hold", 32'(bus6.rm), 32'(0));
      end
    end
    drive(6, 1'b0, 1'b0, 1'b0);
    check_value("b2b_spacing", 32'(c2 - c1), 32'(2 * 6 + 2 + REM_CYC));
    check_value("b2b_first_done", 32'(done1), 32'(1));
    $display("back-to-back spacing=%0d", c2 - c1);
    for (int i = 0; i < 30 && bus6.busy; i++) begin @(posedge clk); #1; end
    check_value("b2b_return_idle", 32'(bus6.busy), 32'(0));

    // Reset asserted between edges mid-sequence
    drive(6, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(6, 1'b0, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check_value("midrst_obs6", 32'(obs(6)), 32'(0));
    check_value("midrst_obs1", 32'(obs(1)), 32'(0));
    check_value("midrst_rm1", 32'(get_rm(1)), 32'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    watch_no_done(20, "midrst_no_done");
    $display("mid-sequence reset done");
    run_seq(6, 6, 1'b0, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
